// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: multiplexes a packed BCD value onto one digit at a time.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int PW       = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic                blank_all,
    output logic [3:0]          BCD,
    output logic                Blanking,
    output logic [DIGITS-1:0]   Anode,
    output logic                load_ack,
    output logic                frame_done
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_pend;
    logic                r_pend_v;
    logic [3:0]          r_bcd;
    logic                r_blank;
    logic [DIGITS-1:0]   r_anode;
    logic                r_ack;
    logic                r_frame;

    logic                w_presc_wrap;
    logic                w_frame;
    logic                w_commit;
    logic [PW-1:0]       w_presc_nx;
    logic [IW-1:0]       w_idx_nx;
    logic [4*DIGITS-1:0] w_shadow_nx;
    logic [DIGITS-1:0]   w_lz;

    always_comb begin
        w_presc_wrap = (r_presc == PS_LAST);
        w_frame      = w_presc_wrap && (r_idx == IDX_LAST);
        w_presc_nx   = w_presc_wrap ? '0 : r_presc + 1'b1;
        w_idx_nx     = r_idx;
        if (w_presc_wrap)
            w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        // A load on the boundary cycle itself bypasses the pending register
        w_commit    = w_frame && (load || r_pend_v);
        w_shadow_nx = r_shadow;
        if (w_frame && load)
            w_shadow_nx = value;
        else if (w_frame && r_pend_v)
            w_shadow_nx = r_pend;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zrun;

    always_comb begin
        w_lz   = '0;
        w_zrun = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zrun  = w_zrun && (w_shadow_nx[4*i +: 4] == 4'd0);
            w_lz[i] = w_zrun;
        end
    end
`else
    assign w_lz = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_anode  <= '1;
            r_blank  <= 1'b1;
            r_bcd    <= '0;
            r_ack    <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_presc  <= w_presc_nx;
            r_idx    <= w_idx_nx;
            r_shadow <= w_shadow_nx;
            if (w_frame) begin
                r_pend_v <= 1'b0;
            end else if (load) begin
                r_pend   <= value;
                r_pend_v <= 1'b1;
            end
            r_anode <= ~(DIGITS'(1) << w_idx_nx);
            r_bcd   <= w_shadow_nx[{w_idx_nx, 2'b00} +: 4];
            r_blank <= blank_all || w_lz[w_idx_nx];
            r_ack   <= w_commit;
            r_frame <= w_frame;
        end
    end

    assign BCD        = r_bcd;
    assign Blanking   = r_blank;
    assign Anode      = r_anode;
    assign load_ack   = r_ack;
    assign frame_done = r_frame;

endmodule
